// File: rtl/serial_pair_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_pair_pkg
// Purpose  : Shared types and constants for the serial pair transmitter.
//            - state_t        : transmitter FSM encoding (IDLE/SEND/DONE)
//            - c_DEFAULT_WIDTH: default word width in bits
//            - cnt_width()    : width of the bit counter for a given WIDTH
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package serial_pair_pkg;

  // Default number of bits per word.
  localparam int c_DEFAULT_WIDTH = 8;

  // Transmitter FSM states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must be able to hold WIDTH itself (the parity bit slot
  // when parity is enabled), hence WIDTH+1 values.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : serial_pair_pkg

`default_nettype wire

// File: rtl/serial_pair_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_pair_tx_if
// Purpose  : Valid/ready word-pair handshake into the serial pair transmitter.
// Signals  : in_valid  - word_one/word_two hold a pair to send
//            in_ready  - transmitter can accept a pair
//            word_one  - first word  (WIDTH bits)
//            word_two  - second word (WIDTH bits)
// Modports : master - producer of word pairs
//            slave  - the transmitter
// Revision : 1.0 - initial release
// ============================================================================
interface serial_pair_tx_if
  import serial_pair_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] word_one;
  logic [WIDTH-1:0] word_two;

  modport master (
    output in_valid,
    output word_one,
    output word_two,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  word_one,
    input  word_two,
    output in_ready
  );

endinterface : serial_pair_tx_if

`default_nettype wire

// File: rtl/serial_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : serial_shift_reg
// Purpose  : Load / shift-right register with LSB serial output. Zeros are
//            shifted in, so once every loaded bit has left the register the
//            serial output returns to 0 by itself.
// Macro    : SERIAL_PAIR_PARITY_EN - when defined, an even-parity bit of the
//            loaded word is appended above the MSB and shifted out last.
// Ports    : clk   - rising-edge clock
//            rstn  - asynchronous active-low reset (clears the register)
//            load  - capture din (has priority over shift)
//            shift - shift right by one, zero fill
//            din   - WIDTH-bit word to load
//            sout  - serial output, bit 0 of the register
// Revision : 1.0 - initial release
// ============================================================================
module serial_shift_reg
  import serial_pair_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

`ifdef SERIAL_PAIR_PARITY_EN
  localparam int c_REG_W = WIDTH + 1;
`else
  localparam int c_REG_W = WIDTH;
`endif

  logic [c_REG_W-1:0] r_data;
  logic [c_REG_W-1:0] w_load_val;

`ifdef SERIAL_PAIR_PARITY_EN
  // Parity sits in the top slot so it follows the MSB onto the line.
  assign w_load_val = {^din, din};
`else
  assign w_load_val = din;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= w_load_val;
    end else if (shift) begin
      r_data <= {1'b0, r_data[c_REG_W-1:1]};
    end
  end

  assign sout = r_data[0];

endmodule : serial_shift_reg

`default_nettype wire

// File: rtl/serial_pair_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_pair_tx
// Purpose  : Accepts a pair of WIDTH-bit words over a valid/ready handshake
//            and shifts them out LSB-first, one bit per clock, on two
//            parallel serial lines. Frames the burst, pulses done after the
//            last bit and reports whether the two words were equal.
// Macro    : SERIAL_PAIR_PARITY_EN - appends an even-parity bit to each line
//            (SEND lasts WIDTH+1 cycles instead of WIDTH).
// Ports    : clk       - rising-edge clock
//            rstn      - asynchronous active-low reset
//            bus       - serial_pair_tx_if.slave (in_valid, in_ready,
//                        word_one, word_two); in_ready == (state == IDLE)
//            x_out_one - serial line one, registered
//            x_out_two - serial line two, registered
//            frame     - high while a data bit is on the lines, registered
//            done      - one-cycle pulse after the last bit, registered
//            match_all - (word_one == word_two) of the last accepted pair
// Revision : 1.0 - initial release
// ============================================================================
module serial_pair_tx
  import serial_pair_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  serial_pair_tx_if.slave  bus,
  output logic             x_out_one,
  output logic             x_out_two,
  output logic             frame,
  output logic             done,
  output logic             match_all
);

  localparam int c_CNT_W = cnt_width(WIDTH);

  // Counter value of the final bit slot of a burst.
`ifdef SERIAL_PAIR_PARITY_EN
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH);
`else
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);
`endif

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_frame;
  logic                 r_done;
  logic                 r_match;

  logic                 w_accept;
  logic                 w_shift;
  logic                 w_sout_one;
  logic                 w_sout_two;

  assign bus.in_ready = (r_state == IDLE);
  assign w_accept     = bus.in_valid && (r_state == IDLE);
  assign w_shift      = (r_state == SEND);

  // --------------------------------------------------------------------------
  // Control FSM. The words are loaded at the accepting edge, so bit 0 is on
  // the lines in the first SEND cycle; each SEND edge advances one bit. The
  // edge that leaves SEND also shifts the last bit out, which leaves both
  // shift registers at zero for DONE and IDLE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_frame <= 1'b0;
      r_done  <= 1'b0;
      r_match <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state <= SEND;
            r_cnt   <= '0;
            r_frame <= 1'b1;
            r_match <= (bus.word_one == bus.word_two);
          end
        end

        SEND: begin
          if (r_cnt == c_LAST) begin
            // Counter parks at the last slot; it is cleared on the next accept.
            r_state <= DONE;
            r_frame <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_frame <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // One shift register per line.
  // --------------------------------------------------------------------------
  serial_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_one (
    .clk   (clk),
    .rstn  (rstn),
    .load  (w_accept),
    .shift (w_shift),
    .din   (bus.word_one),
    .sout  (w_sout_one)
  );

  serial_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_two (
    .clk   (clk),
    .rstn  (rstn),
    .load  (w_accept),
    .shift (w_shift),
    .din   (bus.word_two),
    .sout  (w_sout_two)
  );

  // Shift register LSBs are flop outputs, so the lines are registered.
  assign x_out_one = w_sout_one;
  assign x_out_two = w_sout_two;
  assign frame     = r_frame;
  assign done      = r_done;
  assign match_all = r_match;

endmodule : serial_pair_tx

`default_nettype wire

// File: tb/tb_serial_pair_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_pair_tx
// Purpose  : Directed self-checking bench for serial_pair_tx. Expected bit
//            streams come from the words the bench itself drives.
// Macro    : SERIAL_PAIR_PARITY_EN - bench expects the extra parity slot.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_pair_tx;

  localparam int c_W = 8;
`ifdef SERIAL_PAIR_PARITY_EN
  localparam int c_PAR = 1;
`else
  localparam int c_PAR = 0;
`endif

  logic clk;
  logic rstn;
  logic x_out_one;
  logic x_out_two;
  logic frame;
  logic done;
  logic match_all;

  int    n_checks;
  int    n_errors;
  string cur_test;

  serial_pair_tx_if #(.WIDTH(c_W)) bus ();

  serial_pair_tx #(
    .WIDTH (c_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .x_out_one (x_out_one),
    .x_out_two (x_out_two),
    .frame     (frame),
    .done      (done),
    .match_all (match_all)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tiny equality detector model fed by the two lines: y goes low for the
  // cycle after a framed bit where the lines disagree.
  logic det_y = 1'b1;
  bit   det_en;
  int   det_low;

  always @(posedge clk) det_y <= !frame || (x_out_one == x_out_two);

  always @(negedge clk) begin
    if (!det_en)     det_low <= 0;
    else if (!det_y) det_low <= det_low + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: observed %0h, expected %0h", cur_test, tag, obs, exp);
    end
  endtask

  // Present a pair and return #1 after the accepting edge k.
  task automatic start_pair(input logic [c_W-1:0] a, input logic [c_W-1:0] b);
    bus.word_one = a;
    bus.word_two = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_val("match", 32'(match_all), 32'(a == b));
  endtask

  // Checks cycles k+1 .. k+WIDTH(+1), the DONE cycle and the IDLE cycle.
  task automatic check_burst(input logic [c_W-1:0] a, input logic [c_W-1:0] b);
    logic ea, eb;
    for (int i = 0; i < c_W + c_PAR; i++) begin
      @(negedge clk);
      if (i < c_W) begin
        ea = a[i];
        eb = b[i];
      end else begin
        ea = ^a;
        eb = ^b;
      end
      check_val($sformatf("bit%0d", i),
                32'({frame, done, bus.in_ready, x_out_one, x_out_two}),
                32'({1'b1, 1'b0, 1'b0, ea, eb}));
    end
    @(negedge clk);
    check_val("done_cycle",
              32'({frame, done, bus.in_ready, x_out_one, x_out_two}),
              32'(5'b01000));
    @(negedge clk);
    check_val("idle_cycle", 32'({frame, done, bus.in_ready}), 32'(3'b001));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    det_en       = 1'b0;
    rstn         = 1'b0;
    bus.in_valid = 1'b0;
    bus.word_one = '0;
    bus.word_two = '0;

    // Reset then idle.
    cur_test = "reset";
    #12;
    check_val("in_reset",
              32'({bus.in_ready, x_out_one, x_out_two, frame, done, match_all}),
              32'(6'b100000));
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val($sformatf("idle%0d", i),
                32'({bus.in_ready, x_out_one, x_out_two, frame, done, match_all}),
                32'(6'b100000));
    end

    // Equal words.
    cur_test = "a5_a5";
    start_pair(8'hA5, 8'hA5);
    bus.in_valid = 1'b0;
    check_burst(8'hA5, 8'hA5);

    // Words differing in bit 0 only, observed through the detector model.
    cur_test = "f0_f1";
    start_pair(8'hF0, 8'hF1);
    bus.in_valid = 1'b0;
    det_en = 1'b1;
    check_burst(8'hF0, 8'hF1);
    check_val("det_low_cycles", 32'(det_low), 32'd1);
    det_en = 1'b0;

    // in_valid held: second pair queued on the bus during the first burst.
    cur_test = "held_valid";
    start_pair(8'h3C, 8'h3C);
    bus.word_one = 8'h69;
    bus.word_two = 8'h96;
    check_burst(8'h3C, 8'h3C);
    // Still IDLE with in_valid high: this edge (k+10) accepts the second pair.
    @(posedge clk);
    #1;
    check_val("match2", 32'(match_all), 32'd0);
    bus.in_valid = 1'b0;
    bus.word_one = 8'hFF;
    bus.word_two = 8'h00;
    check_burst(8'h69, 8'h96);

    // Reset pulsed during cycle k+4 (bit 3 of 8'h5A is 1 on both lines).
    cur_test = "mid_reset";
    start_pair(8'h5A, 8'h5A);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val($sformatf("pre_bit%0d", i),
                32'({frame, x_out_one, x_out_two}),
                32'({1'b1, bus.word_one[i], bus.word_one[i]}));
    end
    rstn = 1'b0;
    #1;
    check_val("async_clear",
              32'({x_out_one, x_out_two, frame, done, match_all, bus.in_ready}),
              32'(6'b000001));
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_val($sformatf("no_done%0d", i),
                32'({frame, done, bus.in_ready, x_out_one, x_out_two}),
                32'(5'b00100));
    end
    cur_test = "after_reset";
    start_pair(8'hC3, 8'h3C);
    bus.in_valid = 1'b0;
    check_burst(8'hC3, 8'h3C);

    // Word with odd bit count (parity 1 on line one when enabled).
    cur_test = "w07";
    start_pair(8'h07, 8'h03);
    bus.in_valid = 1'b0;
    check_burst(8'h07, 8'h03);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_serial_pair_tx

`default_nettype wire
